// File: rtl/data_ram_bytewe_pkg.sv
// Shared constants for the byte-enable data RAM: word/lane geometry, counter width
// and the enable-level names used across the data port.
package data_ram_bytewe_pkg;

    localparam logic ENABLE    = 1'b1;
    localparam logic DISABLE   = 1'b0;
    localparam logic ENABLE_N  = 1'b0;
    localparam logic DISABLE_N = 1'b1;

    localparam int WORD_W = 32;
    localparam int BYTES  = 4;
    localparam int CNT_W  = 16;

endpackage

// File: rtl/data_ram_bytewe_ram_out_pipe.sv
// Read-data pipeline: STAGES-deep data+valid register chain with synchronous clear.
// Each data stage loads only when its upstream valid is set, so the output holds between accesses.
module ram_out_pipe #(
    parameter int DATA_W = 32,
    parameter int STAGES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_vld
);

    logic [STAGES-1:0]             vld_p;
    logic [STAGES-1:0][DATA_W-1:0] data_p;
    logic [STAGES:0]               vld_c;
    logic [STAGES:0][DATA_W-1:0]   data_c;

    // Element 0 of the chain is the pipe input, element s+1 is register stage s.
    assign vld_c  = {vld_p, in_vld};
    assign data_c = {data_p, in_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p  <= '0;
            data_p <= '0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                vld_p[s] <= vld_c[s];
                if (vld_c[s])
                    data_p[s] <= data_c[s];
            end
        end
    end

    assign out_data = data_p[STAGES-1];
    assign out_vld  = vld_p[STAGES-1];

endmodule

// File: rtl/data_ram_bytewe.sv
// Single-port 32-bit word RAM with per-byte write enables, read-first data return
// through a configurable pipeline, saturating access counters and a sticky out-of-range flag.
module data_ram_bytewe
    import data_ram_bytewe_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int RD_LAT     = 1,
    parameter int INIT_ZERO  = 1
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              ena,
    input  logic [BYTES-1:0]  wea,
    input  logic [WORD_W-1:0] addra,
    input  logic [WORD_W-1:0] dina,
    output logic [WORD_W-1:0] douta,
    output logic              douta_vld,
    output logic              oor_err,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [WORD_W-1:0] INIT_WORD = (INIT_ZERO != 0) ? '0 : 'x;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

    logic [WORD_W-1:0]     mem [DEPTH] = '{default: INIT_WORD};
    logic [DEPTH_LOG2-1:0] idx;
    logic [WORD_W-1:0]     rd_word_p0;
    logic                  is_wr;
    logic                  in_range;
    logic                  oor_hit;

    assign idx        = addra[DEPTH_LOG2-1:0];
    assign rd_word_p0 = mem[idx];
    assign is_wr      = |wea;
    assign in_range   = (addra < WORD_W'(DEPTH));
    // Case-inequality makes an unknown address count as out of range in simulation.
    assign oor_hit    = ena && (in_range !== 1'b1);

    // The array ignores rsta so a write issued alongside reset is not lost.
    always_ff @(posedge clka) begin
        if (ena) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wea[b])
                    mem[idx][8*b +: 8] <= dina[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            oor_err <= DISABLE;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
        end else if (ena) begin
            if (oor_hit)
                oor_err <= ENABLE;
            if (is_wr)
                wr_cnt <= sat_inc(wr_cnt);
            else
                rd_cnt <= sat_inc(rd_cnt);
        end
    end

    // Stage p0 -> output: old word captured at the access edge travels RD_LAT registers.
    ram_out_pipe #(
        .DATA_W (WORD_W),
        .STAGES (RD_LAT)
    ) u_out_pipe (
        .clk      (clka),
        .rst      (rsta),
        .in_vld   (ena),
        .in_data  (rd_word_p0),
        .out_data (douta),
        .out_vld  (douta_vld)
    );

endmodule

// File: tb/tb_data_ram_bytewe.sv
// Bench for data_ram_bytewe: a latency-1 and a latency-2 instance share one input stream
// and are compared against an array-based reference model, a vector table and hand sequences.
module tb_data_ram_bytewe;

    localparam int DLOG  = 6;
    localparam int DEPTH = 1 << DLOG;

    logic        clk = 1'b0;
    logic        rsta, ena;
    logic [3:0]  wea;
    logic [31:0] addra, dina;

    logic [31:0] d1, d2;
    logic        v1, v2, o1, o2;
    logic [15:0] rc1, rc2, wc1, wc2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_ram_bytewe #(.DEPTH_LOG2(DLOG), .RD_LAT(1), .INIT_ZERO(1)) u_l1 (
        .clka(clk), .rsta(rsta), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .douta(d1), .douta_vld(v1), .oor_err(o1), .rd_cnt(rc1), .wr_cnt(wc1));

    data_ram_bytewe #(.DEPTH_LOG2(DLOG), .RD_LAT(2), .INIT_ZERO(1)) u_l2 (
        .clka(clk), .rsta(rsta), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .douta(d2), .douta_vld(v2), .oor_err(o2), .rd_cnt(rc2), .wr_cnt(wc2));

    // Reference model: word array, access history of the last two edges, counters.
    logic [31:0] ref_mem [DEPTH];
    bit          m_oor;
    int          m_rd, m_wr;
    bit          av0, av1, r0, r1;
    logic [31:0] aw0, aw1;
    logic [31:0] exp_d1, exp_d2;
    bit          exp_v1, exp_v2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        int          idx;
        logic [31:0] old;
        idx = int'(addra % DEPTH);
        old = ref_mem[idx];
        if (ena)
            for (int b = 0; b < 4; b++)
                if (wea[b]) ref_mem[idx][8*b +: 8] = dina[8*b +: 8];
        av1 = av0; aw1 = aw0; r1 = r0;
        av0 = ena; aw0 = old; r0 = rsta;
        if (rsta) begin
            m_oor = 0; m_rd = 0; m_wr = 0;
        end else if (ena) begin
            if (addra >= DEPTH) m_oor = 1;
            if (wea != 0) begin if (m_wr < 65535) m_wr++; end
            else          begin if (m_rd < 65535) m_rd++; end
        end
        exp_v1 = av0 && !r0;
        if (exp_v1) exp_d1 = aw0; else if (r0) exp_d1 = 0;
        exp_v2 = av1 && !r1 && !r0;
        if (exp_v2) exp_d2 = aw1; else if (r0) exp_d2 = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".d1"}, d1, exp_d1);
        chk({tag, ".v1"}, 32'(v1), 32'(exp_v1));
        chk({tag, ".d2"}, d2, exp_d2);
        chk({tag, ".v2"}, 32'(v2), 32'(exp_v2));
        chk({tag, ".oor1"}, 32'(o1), 32'(m_oor));
        chk({tag, ".oor2"}, 32'(o2), 32'(m_oor));
        chk({tag, ".rd1"}, 32'(rc1), 32'(m_rd));
        chk({tag, ".wr1"}, 32'(wc1), 32'(m_wr));
        chk({tag, ".rd2"}, 32'(rc2), 32'(m_rd));
        chk({tag, ".wr2"}, 32'(wc2), 32'(m_wr));
    endtask

    task automatic drive(input logic r, input logic e, input logic [3:0] w,
                         input logic [31:0] a, input logic [31:0] d);
        rsta = r; ena = e; wea = w; addra = a; dina = d;
    endtask

    typedef struct {
        logic        ena;
        logic [3:0]  wea;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] exp_d;
        logic        exp_v;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [15:0] rc_hold;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        m_oor = 0; m_rd = 0; m_wr = 0;
        av0 = 0; av1 = 0; r0 = 0; r1 = 0; aw0 = 0; aw1 = 0;
        exp_d1 = 0; exp_d2 = 0; exp_v1 = 0; exp_v2 = 0;

        // Expected values are for the latency-1 instance, read-first.
        tbl[0]  = '{1'b1, 4'b1110, 32'd5, 32'h12345678, 32'h00000000, 1'b1};
        tbl[1]  = '{1'b1, 4'b0000, 32'd5, 32'h0,        32'h12345600, 1'b1};
        tbl[2]  = '{1'b1, 4'b1111, 32'd7, 32'hAAAA5555, 32'h00000000, 1'b1};
        tbl[3]  = '{1'b1, 4'b1111, 32'd7, 32'h00000000, 32'hAAAA5555, 1'b1};
        tbl[4]  = '{1'b1, 4'b0000, 32'd7, 32'h0,        32'h00000000, 1'b1};
        tbl[5]  = '{1'b0, 4'b1111, 32'd7, 32'hFFFFFFFF, 32'h00000000, 1'b0};
        tbl[6]  = '{1'b1, 4'b0001, 32'd9, 32'h000000EE, 32'h00000000, 1'b1};
        tbl[7]  = '{1'b1, 4'b0000, 32'd9, 32'h0,        32'h000000EE, 1'b1};
        tbl[8]  = '{1'b0, 4'b0000, 32'd9, 32'h0,        32'h000000EE, 1'b0};
        tbl[9]  = '{1'b1, 4'b1000, 32'd9, 32'h11223344, 32'h000000EE, 1'b1};
        tbl[10] = '{1'b1, 4'b0000, 32'd9, 32'h0,        32'h110000EE, 1'b1};
        tbl[11] = '{1'b1, 4'b0110, 32'd9, 32'hAABBCCDD, 32'h110000EE, 1'b1};
        tbl[12] = '{1'b1, 4'b0000, 32'd9, 32'h0,        32'h11BBCCEE, 1'b1};

        // T1 reset held two cycles
        drive(1, 0, 0, 0, 0);
        tick(); tick();
        chk("rst.d1", d1, 0);   chk("rst.v1", 32'(v1), 0);
        chk("rst.d2", d2, 0);   chk("rst.v2", 32'(v2), 0);
        chk("rst.oor", 32'(o1), 0);
        chk("rst.rd", 32'(rc1), 0); chk("rst.wr", 32'(wc1), 0);

        // T2/T3 byte lanes and read-first via the vector table
        for (int i = 0; i < 13; i++) begin
            drive(0, tbl[i].ena, tbl[i].wea, tbl[i].addr, tbl[i].din);
            tick();
            chk($sformatf("tbl%0d.d", i), d1, tbl[i].exp_d);
            chk($sformatf("tbl%0d.v", i), 32'(v1), 32'(tbl[i].exp_v));
            chk_all($sformatf("tbl%0d", i));
        end

        // T4 streaming reads after preload mem[i]=i
        drive(1, 0, 0, 0, 0); tick();
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 4'hF, i, i); tick();
        end
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 4'h0, i, 32'hDEAD0000);
            tick();
            chk("stream.d1", d1, i);
            chk("stream.v1", 32'(v1), 1);
            if (i > 0) begin
                chk("stream.d2", d2, i - 1);
                chk("stream.v2", 32'(v2), 1);
            end
        end
        drive(0, 0, 0, 0, 0); tick();
        chk("stream.d2last", d2, 15);
        chk("stream.v2last", 32'(v2), 1);
        chk("stream.v1idle", 32'(v1), 0);
        chk("stream.rdcnt", 32'(rc1), 16);
        chk_all("stream");

        // T5 out of range wraps, flag sticky, ena=0 gating
        drive(0, 1, 0, DEPTH + 3, 0); tick();
        chk("oor.flag", 32'(o1), 1);
        chk("oor.wrap", d1, 3);
        drive(0, 1, 0, 4, 0); tick();
        chk("oor.sticky", 32'(o1), 1);
        chk_all("oor");
        rc_hold = rc1;
        drive(0, 0, 4'hF, 4, 32'h55555555); tick();
        drive(0, 0, 4'h0, 2, 0); tick();
        chk("gate.hold", d1, 4);
        chk("gate.hold2", d2, 4);
        chk("gate.v1", 32'(v1), 0);
        chk("gate.rd", 32'(rc1), 32'(rc_hold));
        chk_all("gate");
        drive(0, 1, 0, 4, 0); tick();
        chk("gate.nowrite", d1, 4);

        // Randomised traffic against the model, including reset-with-access
        for (int n = 0; n < 500; n++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                  4'($urandom), $urandom_range(0, DEPTH + 16), $urandom);
            tick();
            chk_all("rand");
        end

        // T6 write-counter saturation, then reset with a latency-2 read in flight
        drive(1, 0, 0, 0, 0); tick();
        for (int n = 0; n < 70000; n++) begin
            drive(0, 1, 4'hF, $urandom_range(0, DEPTH - 1), $urandom);
            tick();
        end
        chk("sat.wr1", 32'(wc1), 32'hFFFF);
        chk("sat.wr2", 32'(wc2), 32'hFFFF);
        chk_all("sat");
        drive(0, 1, 0, 1, 0); tick();
        drive(1, 0, 0, 0, 0); tick();
        chk("flight.v2", 32'(v2), 0);
        chk("flight.wr", 32'(wc2), 0);
        chk("flight.rd", 32'(rc2), 0);
        chk_all("flight");
        drive(0, 0, 0, 0, 0); tick();
        chk("flight.v2after", 32'(v2), 0);
        chk_all("flight2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
